knn_dist_stream: RTL and testbench
==================================

# knn_dist_stream

Producer side of the kNN sorting datapath: streams training points, computes each point's squared Euclidean distance to a latched test point, and presents the result on `DATA_OUT` with a one-cycle `ready` strobe. It issues exactly `npoints` strobes per run, then asserts `done`. It drives the `DATA_IN`, `ready` and `done` inputs of the 4-entry insertion sorter directly. A `clear` pulse at run start resets the sorter's contents and its index counter.

## Interface
- `W`, 32, distance width; must match the sorter's `W`.
- `DW`, 16, unsigned coordinate width; `W` must be at least `2*DW`.
- `NW`, 8, point-count and index width; equals `W/4`.

- `clk` in 1 — system clock.
- `rst` in 1 — reset, asynchronous, active-high.
- `start` in 1 — begin a run; sampled only in IDLE and DONE.
- `npoints` in NW — number of training points in the run; latched on `start`.
- `test_x`, `test_y` in DW each — test point; latched on `start`.
- `pt_valid` in 1 — training point offered.
- `pt_x`, `pt_y` in DW each — training point coordinates.
- `pt_ready` out 1 — point accepted when `pt_valid & pt_ready`.
- `DATA_OUT` out W — squared distance to the sorter.
- `ready` out 1 — one-cycle strobe, "`DATA_OUT` valid".
- `done` out 1 — run complete; held high until the next run.
- `clear` out 1 — one-cycle pulse on run start; ORed into the sorter's `rst`.
- `busy` out 1 — high in RUN and DRAIN.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE or DONE with `start`=1:
  - latch `test_x`, `test_y`, `npoints`;
  - zero `in_cnt` and `out_cnt`;
  - pulse `clear` in the following cycle;
  - go to RUN, or to DONE if `npoints`=0 (no strobes are issued, `done` rises).
- RUN:
  - `pt_ready`=1;
  - each handshake pushes the point into the pipeline and increments `in_cnt`;
  - the handshake that makes `in_cnt`=`npoints` moves the FSM to DRAIN in the next cycle;
  - `pt_ready` is 0 in DRAIN, so no extra point is ever accepted.
- DRAIN: wait until `out_cnt`=`npoints`, then go to DONE.
- DONE: `done`=1; `start` begins a new run and `done` falls in that cycle.
- `start` in RUN or DRAIN is ignored.
- `out_cnt` increments on every `ready` strobe.

Arithmetic:
- `dx` = |`pt_x` − `test_x`| and `dy` = |`pt_y` − `test_y`|, each DW bits, unsigned.
- sum = `dx`² + `dy`², 2·DW+1 bits.
- If the sum exceeds 2^W−2, `DATA_OUT` saturates to 2^W−2. The value therefore stays strictly below the sorter's all-ones reset sentinel and still fills empty slots.

Boundaries:
- `npoints`=255 is valid; the counters are NW+1 bits internally so they do not wrap.
- `pt_valid` gaps insert bubbles with no strobe; strobes stay in acceptance order.
- `rst` mid-run returns to IDLE immediately.

## Timing
- Reset values: `pt_ready`=0, `DATA_OUT`=0, `ready`=0, `done`=0, `clear`=0, `busy`=0.
- Pipeline latency is 2 cycles:
  - handshake at cycle t;
  - `dx`/`dy` registered at t+1;
  - `DATA_OUT` and `ready` registered at t+2.
- Back-to-back points give back-to-back strobes (1 point/cycle).
- `clear` occurs in the cycle after `start` (`start` at t0, `clear` at t0+1, FSM already in RUN at t0+1). The first possible handshake is t0+1, so the first strobe is no earlier than t0+3, after `clear` has reset the sorter.
- `done` rises the cycle after the last strobe, never together with a strobe; the sorter masks index updates while `done`=1.
- `DATA_OUT` holds its last value between strobes.

## Structure
- Shared header `knn_defs.vh`: `W`, `DW`, `NW`, state encodings (IDLE=0, RUN=1, DRAIN=2, DONE=3), saturation constant.
- Sub-module `knn_dist_sq`:
  - 2-stage pipeline computing abs-diff, squares, sum and saturation;
  - valid bit travels alongside the data.
- Top level holds the FSM, counters, latches and `clear` generator.

## Test plan
- Reset: after `rst`, every output is 0.
- Single point: test (3,4), `npoints`=1, point (0,0) → one strobe with `DATA_OUT`=25; `done` one cycle later.
- Streaming: test (10,10), `npoints`=4, points (10,10),(13,14),(0,0),(10,11) offered back-to-back.
  - Expect 4 consecutive strobes with 0, 25, 200, 1; `pt_ready` low in DRAIN.
  - Sorter outputs indices 0, 3, 1, 2.
- Saturation: test (0,0), point (65535,65535) → `DATA_OUT`=32'hFFFFFFFE.
- Backpressure/bubbles: `pt_valid` toggling every other cycle with `npoints`=3 → 3 strobes spaced 2 cycles apart.
  - A 4th `pt_valid` offered while in DRAIN is not accepted.
- Edge runs:
  - `npoints`=0 → `clear` pulse, `done` with no strobe.
  - `start` mid-RUN is ignored.
  - `rst` mid-RUN → IDLE with all outputs 0; a new run then proceeds normally.

Source files
------------

// File: rtl/knn_dist_stream_pkg.sv
// Shared types and constants for the kNN distance streamer.
// Widths, FSM encoding, stage bundle and arithmetic helpers.
package knn_dist_stream_pkg;

  localparam int W  = 32;
  localparam int DW = 16;
  localparam int NW = 8;

  localparam int SW = 2 * DW + 1;

  localparam logic [W-1:0] SAT =
    {{(W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] dx;
    logic [DW-1:0] dy;
  } diff_t;

  function automatic logic [DW-1:0] abs_diff(
    input logic [DW-1:0] a,
    input logic [DW-1:0] b
  );
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Keep results strictly below the sorter's all-ones sentinel.
  function automatic logic [W-1:0] sat_sum(
    input logic [SW-1:0] s
  );
    logic [W:0] se;
    se = (W + 1)'(s);
    if (se > {1'b0, SAT})
      return SAT;
    return se[W-1:0];
  endfunction

endpackage

// File: rtl/knn_dist_stream_if.sv
// Training-point valid/ready stream.
// master drives points, slave accepts them.
interface knn_dist_stream_if;
  import knn_dist_stream_pkg::*;

  logic          pt_valid;
  logic          pt_ready;
  logic [DW-1:0] pt_x;
  logic [DW-1:0] pt_y;

  modport master (
    output pt_valid,
    output pt_x,
    output pt_y,
    input  pt_ready
  );

  modport slave (
    input  pt_valid,
    input  pt_x,
    input  pt_y,
    output pt_ready
  );

endinterface

// File: rtl/knn_dist_stream_dist_sq.sv
// Two-stage squared-distance pipeline.
// Stage 1: abs diffs; stage 2: squares, sum, saturate.
module knn_dist_stream_dist_sq
  import knn_dist_stream_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_v,
  input  logic [DW-1:0] pt_x,
  input  logic [DW-1:0] pt_y,
  input  logic [DW-1:0] ref_x,
  input  logic [DW-1:0] ref_y,
  output logic          out_v,
  output logic [W-1:0]  out_d
);

  diff_t          s1;
  logic [2*DW-1:0] ex;
  logic [2*DW-1:0] ey;
  logic [2*DW-1:0] sq_x;
  logic [2*DW-1:0] sq_y;
  logic [SW-1:0]   sum;

  assign ex   = {{DW{1'b0}}, s1.dx};
  assign ey   = {{DW{1'b0}}, s1.dy};
  assign sq_x = ex * ex;
  assign sq_y = ey * ey;
  assign sum  = {1'b0, sq_x} + {1'b0, sq_y};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
    end else begin
      s1.v <= in_v;
      if (in_v) begin
        s1.dx <= abs_diff(pt_x, ref_x);
        s1.dy <= abs_diff(pt_y, ref_y);
      end
    end
  end

  // Result register holds between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_v <= 1'b0;
      out_d <= '0;
    end else begin
      out_v <= s1.v;
      if (s1.v)
        out_d <= sat_sum(sum);
    end
  end

endmodule

// File: rtl/knn_dist_stream.sv
// kNN producer: streams points, emits squared distances
// to a latched test point, then signals done.
module knn_dist_stream
  import knn_dist_stream_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NW-1:0]          npoints,
  input  logic [DW-1:0]          test_x,
  input  logic [DW-1:0]          test_y,
  knn_dist_stream_if.slave       pt,
  output logic [W-1:0]           DATA_OUT,
  output logic                   ready,
  output logic                   done,
  output logic                   clear,
  output logic                   busy
);

  localparam logic [NW:0] ONE =
    {{NW{1'b0}}, 1'b1};

  state_t        state;
  state_t        state_n;
  logic [NW:0]   n_lat;
  logic [NW:0]   in_cnt;
  logic [NW:0]   out_cnt;
  logic [NW:0]   in_nxt;
  logic [NW:0]   out_nxt;
  logic [DW-1:0] tx;
  logic [DW-1:0] ty;
  logic          go;
  logic          hs;

  assign pt.pt_ready = (state == RUN);
  assign hs          = pt.pt_valid & pt.pt_ready;
  assign done        = (state == DONE);
  assign busy        = (state == RUN) |
                       (state == DRAIN);

  assign in_nxt  = in_cnt + ONE;
  // Count the strobe in flight so done follows it by one cycle.
  assign out_nxt = out_cnt + {{NW{1'b0}}, ready};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    go      = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          go      = 1'b1;
          state_n = (npoints == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (hs && (in_nxt == n_lat))
          state_n = DRAIN;
      end
      DRAIN: begin
        if (out_nxt == n_lat)
          state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_lat   <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
      tx      <= '0;
      ty      <= '0;
      clear   <= 1'b0;
    end else begin
      clear <= go;
      if (go) begin
        n_lat   <= {1'b0, npoints};
        tx      <= test_x;
        ty      <= test_y;
        in_cnt  <= '0;
        out_cnt <= '0;
      end else begin
        if (hs)
          in_cnt <= in_nxt;
        if (ready)
          out_cnt <= out_nxt;
      end
    end
  end

  knn_dist_stream_dist_sq u_dist (
    .clk   (clk),
    .rst   (rst),
    .in_v  (hs),
    .pt_x  (pt.pt_x),
    .pt_y  (pt.pt_y),
    .ref_x (tx),
    .ref_y (ty),
    .out_v (ready),
    .out_d (DATA_OUT)
  );

endmodule

// File: tb/tb_knn_dist_stream.sv
// Bench for knn_dist_stream: directed and random runs
// checked against a plain-arithmetic distance model.
module tb_knn_dist_stream;
  import knn_dist_stream_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NW-1:0] npoints;
  logic [DW-1:0] test_x;
  logic [DW-1:0] test_y;
  logic [W-1:0]  DATA_OUT;
  logic          ready;
  logic          done;
  logic          clear;
  logic          busy;

  knn_dist_stream_if pif();

  always #5 clk = ~clk;

  knn_dist_stream dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .npoints  (npoints),
    .test_x   (test_x),
    .test_y   (test_y),
    .pt       (pif),
    .DATA_OUT (DATA_OUT),
    .ready    (ready),
    .done     (done),
    .clear    (clear),
    .busy     (busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [W-1:0] got_v[$];
  int           got_c[$];
  int           hs_cnt = 0;
  int           done_cyc = -1;
  int           overlap = 0;
  int           clear_cyc = 0;
  logic         done_q = 1'b0;

  int           tx_m, ty_m;
  int           px_q[$];
  int           py_q[$];
  logic [W-1:0] exp_q[$];
  int           ptr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ready) begin
      got_v.push_back(DATA_OUT);
      got_c.push_back(cyc);
      if (done) overlap++;
    end
    if (pif.pt_valid && pif.pt_ready) hs_cnt++;
    if (done && !done_q && done_cyc < 0) done_cyc = cyc;
    done_q = done;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_dist(input int tx, input int ty,
                                            input int px, input int py);
    longint dx, dy, s;
    dx = (px > tx) ? px - tx : tx - px;
    dy = (py > ty) ? py - ty : ty - py;
    s  = dx * dx + dy * dy;
    if (s > 64'd4294967294) return 32'hFFFF_FFFE;
    return s[31:0];
  endfunction

  task automatic start_run(input int tx, input int ty, input int n);
    got_v.delete();
    got_c.delete();
    px_q.delete();
    py_q.delete();
    exp_q.delete();
    ptr = 0;
    hs_cnt = 0;
    done_cyc = -1;
    overlap = 0;
    tx_m = tx;
    ty_m = ty;
    start = 1'b1;
    npoints = NW'(n);
    test_x = DW'(tx);
    test_y = DW'(ty);
    @(posedge clk); #1;
    start = 1'b0;
    clear_cyc = cyc;
    chk("clear_pulse", clear, 1);
  endtask

  task automatic add_pt(input int x, input int y);
    px_q.push_back(x);
    py_q.push_back(y);
    exp_q.push_back(ref_dist(tx_m, ty_m, x, y));
  endtask

  task automatic offer(input int n, input bit gap);
    int got = 0;
    int budget = 0;
    bit tog = 1'b1;
    bit hs;
    while (got < n && budget < 1000) begin
      pif.pt_valid = gap ? tog : 1'b1;
      pif.pt_x = DW'(px_q[ptr]);
      pif.pt_y = DW'(py_q[ptr]);
      @(negedge clk);
      hs = pif.pt_valid && pif.pt_ready;
      @(posedge clk); #1;
      if (hs) begin
        got++;
        ptr++;
      end
      tog = !tog;
      budget++;
    end
    pif.pt_valid = 1'b0;
    if (got < n) chk("offer_timeout", got, n);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk("done_wait", done, 1);
  endtask

  task automatic check_run(input string tag, input int n, input int spacing);
    @(negedge clk); #1;
    chk({tag, "_count"}, got_v.size(), n);
    chk({tag, "_accepted"}, hs_cnt, n);
    chk({tag, "_no_overlap"}, overlap, 0);
    for (int i = 0; i < n && i < got_v.size(); i++) begin
      chk({tag, "_value"}, got_v[i], exp_q[i]);
      if (i > 0 && spacing > 0)
        chk({tag, "_spacing"}, got_c[i] - got_c[i-1], spacing);
    end
    if (got_v.size() > 0) begin
      chk({tag, "_after_clear"}, got_c[0] >= clear_cyc + 2, 1);
      chk({tag, "_done_time"}, done_cyc, got_c[got_v.size()-1] + 1);
    end
    @(posedge clk); #1;
  endtask

  logic [W-1:0] k4[4];

  initial begin
    k4 = '{32'd0, 32'd25, 32'd200, 32'd1};
    rst = 1'b1;
    start = 1'b0;
    npoints = '0;
    test_x = '0;
    test_y = '0;
    pif.pt_valid = 1'b0;
    pif.pt_x = '0;
    pif.pt_y = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pt_ready", pif.pt_ready, 0);
    chk("rst_data", DATA_OUT, 0);
    chk("rst_ready", ready, 0);
    chk("rst_done", done, 0);
    chk("rst_clear", clear, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    start_run(3, 4, 1);
    chk("single_busy", busy, 1);
    add_pt(0, 0);
    offer(1, 1'b0);
    wait_done(20);
    check_run("single", 1, 0);
    chk("single_25", got_v.size() > 0 ? got_v[0] : '1, 25);

    start_run(10, 10, 4);
    add_pt(10, 10);
    add_pt(13, 14);
    add_pt(0, 0);
    add_pt(10, 11);
    offer(4, 1'b0);
    chk("drain_pt_ready", pif.pt_ready, 0);
    chk("drain_busy", busy, 1);
    wait_done(20);
    check_run("stream", 4, 1);
    for (int i = 0; i < 4 && i < got_v.size(); i++)
      chk("stream_const", got_v[i], k4[i]);

    start_run(0, 0, 1);
    add_pt(65535, 65535);
    offer(1, 1'b0);
    wait_done(20);
    check_run("sat", 1, 0);
    chk("sat_const", got_v.size() > 0 ? got_v[0] : '0, 32'hFFFF_FFFE);

    start_run(100, 200, 3);
    add_pt(0, 0);
    add_pt(150, 170);
    add_pt(40000, 9);
    offer(3, 1'b1);
    pif.pt_valid = 1'b1;
    pif.pt_x = 16'd1;
    pif.pt_y = 16'd1;
    wait_done(20);
    pif.pt_valid = 1'b0;
    check_run("gap", 3, 2);

    start_run($urandom_range(0, 65535), $urandom_range(0, 65535), 20);
    for (int i = 0; i < 20; i++)
      add_pt($urandom_range(0, 65535), $urandom_range(0, 65535));
    offer(20, 1'b0);
    wait_done(20);
    check_run("rand20", 20, 1);

    start_run(5, 5, 0);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("zero_no_strobe", got_v.size(), 0);
    chk("zero_clear_low", clear, 0);

    start_run(7, 9, 3);
    add_pt(1, 2);
    add_pt(300, 9);
    add_pt(7, 1000);
    offer(1, 1'b0);
    npoints = 8'd1;
    test_x = '0;
    test_y = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mid_start_busy", busy, 1);
    chk("mid_start_clear", clear, 0);
    offer(2, 1'b0);
    wait_done(20);
    check_run("midstart", 3, 0);

    start_run(1, 2, 5);
    for (int i = 0; i < 5; i++)
      add_pt($urandom_range(0, 65535), $urandom_range(0, 65535));
    offer(2, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_pt_ready", pif.pt_ready, 0);
    chk("mrst_data", DATA_OUT, 0);
    chk("mrst_ready", ready, 0);
    chk("mrst_done", done, 0);
    chk("mrst_clear", clear, 0);
    chk("mrst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    start_run(50, 60, 2);
    add_pt(53, 64);
    add_pt(60000, 60000);
    offer(2, 1'b0);
    wait_done(20);
    check_run("after_rst", 2, 1);

    start_run($urandom_range(0, 65535), $urandom_range(0, 65535), 255);
    for (int i = 0; i < 255; i++)
      add_pt($urandom_range(0, 65535), $urandom_range(0, 65535));
    offer(255, 1'b0);
    wait_done(20);
    check_run("full", 255, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
